// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time configurable serial pattern detector with overlap/sticky modes and a saturating match counter
module seq_detector_param #(
  parameter int N_MAX = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic [N_MAX-1:0] pattern,
  input  logic [LEN_W-1:0] plen,
  input  logic             overlap,
  input  logic             sticky,
  input  logic             clear,
  output logic             y,
  output logic             found,
  output logic [CNT_W-1:0] count,
  output logic             cfg_err
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t           r_state, w_state_nxt;
  logic [N_MAX-1:0] r_hist, w_win, w_mask;
  logic [LEN_W-1:0] r_fill;
  logic [CNT_W-1:0] r_count;
  logic             r_y, r_found, r_cfg_err;
  logic             w_legal, w_take, w_match, w_y_nxt;
  assign w_win   = {r_hist[N_MAX-2:0], x};
  assign w_legal = (plen != '0) && (plen <= LEN_W'(N_MAX));
  assign w_take  = en && (r_state == SEARCH);
  assign w_match = w_take && w_legal && (({1'b0, r_fill} + 1'b1) >= {1'b0, plen}) && (((w_win ^ pattern) & w_mask) == '0);
  // select the low plen bits of the window for comparison
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_MAX; i++) w_mask[i] = (i < int'(plen));
  end
  // state register; clear and reset both return to SEARCH
  always_ff @(posedge clk) begin
    if (reset || clear) r_state <= SEARCH;
    else r_state <= w_state_nxt;
  end
  // a match with sticky set locks the detector
  always_comb begin
    w_state_nxt = (r_state == SEARCH && w_match && sticky) ? LOCKED : r_state;
  end
  // y is a one-cycle pulse in SEARCH and held high while LOCKED
  always_comb begin
    w_y_nxt = (r_state == LOCKED) || w_match;
  end
  // history, fill, flags and saturating counter; bits are dropped while LOCKED or clearing
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_found <= 1'b0;
      r_y     <= 1'b0;
    end else begin
      r_y <= w_y_nxt;
      if (w_take) begin
        r_hist <= w_win;
        r_fill <= (w_match && !overlap) ? '0 : (r_fill != LEN_W'(N_MAX)) ? r_fill + 1'b1 : r_fill;
      end
      if (w_match) begin
        r_found <= 1'b1;
        r_count <= (r_count != '1) ? r_count + 1'b1 : r_count;
      end
    end
  end
  // configuration check keeps tracking plen through clear
  always_ff @(posedge clk) begin
    if (reset) r_cfg_err <= 1'b0;
    else r_cfg_err <= !w_legal;
  end
  assign y       = r_y;
  assign found   = r_found;
  assign count   = r_count;
  assign cfg_err = r_cfg_err;
endmodule
